// File: rtl/cla3_chunk_sequencer_if.sv
// Handshake and CLA-slice bundle for cla3_chunk_sequencer.
// The sequencer is the slave side; the producer/consumer/slice environment is the master.
interface cla3_chunk_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [2:0]       slice_a;
    logic [2:0]       slice_b;
    logic             slice_cin;
    logic [2:0]       slice_s;
    logic             slice_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, slice_s, slice_cout, out_ready,
        output in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, slice_s, slice_cout, out_ready,
        input  in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/cla3_chunk_sequencer.sv
// Multi-cycle WIDTH-bit adder that streams 3-bit chunks, LSB first, through an external
// combinational 3-bit CLA slice, rippling the carry between cycles. All outputs are registered.
module cla3_chunk_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla3_chunk_sequencer_if.slave  bus
);
    localparam int CW     = 3;
    localparam int NCHUNK = (WIDTH + CW - 1) / CW;
    localparam int PADW   = CW * NCHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] IDX_ZERO = '0;
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [CW-1:0] chunk_get(input logic [PADW-1:0] vec,
                                                input logic [IDXW-1:0] idx);
        logic [CW-1:0] res;
        res = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) begin
                res = vec[k*CW +: CW];
            end
        end
        return res;
    endfunction

    function automatic logic [PADW-1:0] chunk_put(input logic [PADW-1:0] vec,
                                                  input logic [IDXW-1:0] idx,
                                                  input logic [CW-1:0]   val);
        logic [PADW-1:0] res;
        res = vec;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) begin
                res[k*CW +: CW] = val;
            end
        end
        return res;
    endfunction

    logic [1:0]       state_r,     state_s;
    logic [IDXW-1:0]  idx_r,       idx_s;
    logic [PADW-1:0]  a_r,         a_s;
    logic [PADW-1:0]  b_r,         b_s;
    logic [PADW-1:0]  sum_r,       sum_s;
    logic [CW-1:0]    slice_a_r,   slice_a_s;
    logic [CW-1:0]    slice_b_r,   slice_b_s;
    logic             slice_cin_r, slice_cin_s;
    logic [WIDTH-1:0] out_sum_r,   out_sum_s;
    logic             out_cout_r,  out_cout_s;
    logic             out_valid_r, out_valid_s;
    logic             in_ready_r,  in_ready_s;
    logic             busy_r,      busy_s;

    logic [PADW-1:0]  a_pad_s;
    logic [PADW-1:0]  b_pad_s;
    logic [PADW:0]    full_s;

    assign a_pad_s = PADW'(bus.in_a);
    assign b_pad_s = PADW'(bus.in_b);

    // slice_cin_r doubles as the inter-chunk carry register; slice outputs are the next chunk.
    // Bits of full_s above WIDTH are always zero because the operands are zero-padded,
    // so OR-reducing them yields bit WIDTH regardless of WIDTH % 3.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        a_s         = a_r;
        b_s         = b_r;
        sum_s       = sum_r;
        slice_a_s   = 3'd0;
        slice_b_s   = 3'd0;
        slice_cin_s = 1'b0;
        out_sum_s   = out_sum_r;
        out_cout_s  = out_cout_r;
        out_valid_s = 1'b0;
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        full_s      = {bus.slice_cout, chunk_put(sum_r, idx_r, bus.slice_s)};

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    a_s         = a_pad_s;
                    b_s         = b_pad_s;
                    idx_s       = IDX_ZERO;
                    state_s     = ST_RUN;
                    slice_a_s   = a_pad_s[CW-1:0];
                    slice_b_s   = b_pad_s[CW-1:0];
                    slice_cin_s = bus.in_cin;
                end else begin
                    in_ready_s  = 1'b1;
                    busy_s      = 1'b0;
                end
            end
            ST_RUN: begin
                sum_s = full_s[PADW-1:0];
                if (idx_r == IDX_LAST) begin
                    state_s     = ST_DONE;
                    out_sum_s   = full_s[WIDTH-1:0];
                    out_cout_s  = |full_s[PADW:WIDTH];
                    out_valid_s = 1'b1;
                end else begin
                    idx_s       = idx_r + IDX_ONE;
                    slice_a_s   = chunk_get(a_r, idx_r + IDX_ONE);
                    slice_b_s   = chunk_get(b_r, idx_r + IDX_ONE);
                    slice_cin_s = bus.slice_cout;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s     = ST_IDLE;
                    in_ready_s  = 1'b1;
                    busy_s      = 1'b0;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any add in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            slice_a_r   <= 3'd0;
            slice_b_r   <= 3'd0;
            slice_cin_r <= 1'b0;
            out_sum_r   <= '0;
            out_cout_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            a_r         <= a_s;
            b_r         <= b_s;
            sum_r       <= sum_s;
            slice_a_r   <= slice_a_s;
            slice_b_r   <= slice_b_s;
            slice_cin_r <= slice_cin_s;
            out_sum_r   <= out_sum_s;
            out_cout_r  <= out_cout_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.slice_a   = slice_a_r;
    assign bus.slice_b   = slice_b_r;
    assign bus.slice_cin = slice_cin_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_cla3_chunk_sequencer.sv
// Self-checking bench for cla3_chunk_sequencer: a WIDTH=12 and a WIDTH=10 instance,
// each wired to a behavioural 3-bit slice, with a scoreboard queue of A+B+cin results.
module tb_cla3_chunk_sequencer;
    localparam int W   = 12;
    localparam int W10 = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla3_chunk_sequencer_if #(.WIDTH(W))   bus();
    cla3_chunk_sequencer_if #(.WIDTH(W10)) bus10();

    assign {bus.slice_cout, bus.slice_s}     = 4'(bus.slice_a) + 4'(bus.slice_b) + 4'(bus.slice_cin);
    assign {bus10.slice_cout, bus10.slice_s} = 4'(bus10.slice_a) + 4'(bus10.slice_b) + 4'(bus10.slice_cin);

    cla3_chunk_sequencer #(.WIDTH(W))   dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    cla3_chunk_sequencer #(.WIDTH(W10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom_range(0, 4095);
        bus.in_b     = $urandom_range(0, 4095);
    endtask

    task automatic collect(input int budget, input bit rand_stall);
        int n;
        bit got;
        logic [W:0] exp;
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            if (rand_stall) bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_sum",  64'(bus.out_sum),  64'(exp[W-1:0]));
                    check("out_cout", 64'(bus.out_cout), 64'(exp[W]));
                end
            end
            @(negedge clk);
            n++;
        end
        if (!got) check("result_timeout", 64'd0, 64'd1);
        else      check("out_valid_drop", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int n;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_cin      = 1'b0;
        bus.out_ready   = 1'b1;
        bus10.in_valid  = 1'b0;
        bus10.in_a      = '0;
        bus10.in_b      = '0;
        bus10.in_cin    = 1'b0;
        bus10.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum",   64'(bus.out_sum),   64'd0);
        check("rst_out_cout",  64'(bus.out_cout),  64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_slice_a",   64'(bus.slice_a),   64'd0);
        check("rst_slice_b",   64'(bus.slice_b),   64'd0);
        check("rst_slice_cin", 64'(bus.slice_cin), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xFFF + 0x001: carry ripples through every chunk
        send(12'hFFF, 12'h001, 1'b0);
        check("t1_slice_a0",   64'(bus.slice_a),   64'd7);
        check("t1_slice_b0",   64'(bus.slice_b),   64'd1);
        check("t1_slice_cin0", 64'(bus.slice_cin), 64'd0);
        check("t1_busy",       64'(bus.busy),      64'd1);
        check("t1_in_ready",   64'(bus.in_ready),  64'd0);
        @(negedge clk);
        check("t1_slice_cin1", 64'(bus.slice_cin), 64'd1);
        @(negedge clk);
        check("t1_slice_cin2", 64'(bus.slice_cin), 64'd1);
        @(negedge clk);
        check("t1_slice_cin3", 64'(bus.slice_cin), 64'd1);
        check("t1_valid_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_lat4", 64'(bus.out_valid), 64'd1);
        check("t1_sum",        64'(bus.out_sum),   64'h000);
        check("t1_cout",       64'(bus.out_cout),  64'd1);
        collect(1, 1'b0);

        // 0x5A5 + 0x0F0 + 1 under backpressure, with ignored in_valid pulses
        bus.out_ready = 1'b0;
        send(12'h5A5, 12'h0F0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_sum",   64'(bus.out_sum),   64'h696);
        check("bp_cout",  64'(bus.out_cout),  64'd0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_a     = 12'h7FF;
            bus.in_b     = 12'h001;
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_sum",   64'(bus.out_sum),   64'h696);
            check("bp_hold_cout",  64'(bus.out_cout),  64'd0);
            check("bp_in_ready",   64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        collect(1, 1'b0);
        check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_idle_busy",     64'(bus.busy),     64'd0);

        // WIDTH=10: carry taken from padded sum bit 10
        bus10.in_valid = 1'b1;
        bus10.in_a     = 10'h3FF;
        bus10.in_b     = 10'h001;
        bus10.in_cin   = 1'b0;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("w10_valid_early", 64'(bus10.out_valid), 64'd0);
        @(negedge clk);
        check("w10_valid", 64'(bus10.out_valid), 64'd1);
        check("w10_sum",   64'(bus10.out_sum),   64'h000);
        check("w10_cout",  64'(bus10.out_cout),  64'd1);
        @(negedge clk);

        // Asynchronous reset in the second RUN cycle
        send(12'h111, 12'h222, 1'b0);
        @(negedge clk);
        check("mid_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_out_sum",   64'(bus.out_sum),   64'd0);
        check("mid_out_cout",  64'(bus.out_cout),  64'd0);
        check("mid_busy",      64'(bus.busy),      64'd0);
        check("mid_slice_a",   64'(bus.slice_a),   64'd0);
        check("mid_slice_b",   64'(bus.slice_b),   64'd0);
        check("mid_slice_cin", 64'(bus.slice_cin), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(12'h123, 12'h456, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("post_rst_sum_direct", 64'(bus.out_valid ? 12'h000 : 12'h579), 64'h579);
        @(negedge clk);
        check("post_rst_sum",  64'(bus.out_sum),  64'h579);
        check("post_rst_cout", 64'(bus.out_cout), 64'd0);
        collect(4, 1'b0);

        // Random operands with random consumer stalls
        for (int i = 0; i < 500; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            collect(40, 1'b1);
        end
        bus.out_ready = 1'b1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
